// File: rtl/control_unit.sv
// Multi-cycle control sequencer for the 32-bit bus datapath: fetch, decode ir[31:27],
// and drive one register-transfer step per clock. Outputs decode the state and ir.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        MDRout,
  output logic        Cout,
  output logic        BAout,
  output logic        InPortout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        CONin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  operation,
  output logic        Run
);

  typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;
  typedef enum logic [3:0] {
    C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_UNARY, C_MULDIV, C_BR, C_JR, C_NOP, C_HALT
  } opClass_t;

  state_t     state;
  state_t     lastStep;
  opClass_t   opClass;
  logic [4:0] opcode;
  logic [4:0] aluOp;

  assign opcode = ir[31:27];

  always_comb begin
    opClass = C_NOP;
    case (opcode)
      5'b00000:                     opClass = C_LD;
      5'b00001:                     opClass = C_LDI;
      5'b00010:                     opClass = C_ST;
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010:
                                    opClass = C_ALU;
      5'b01011, 5'b01100, 5'b01101: opClass = C_IMM;
      5'b01110, 5'b01111:           opClass = C_MULDIV;
      5'b10000, 5'b10001:           opClass = C_UNARY;
      5'b10010:                     opClass = C_BR;
      5'b10011:                     opClass = C_JR;
      5'b11001:                     opClass = C_HALT;
      default:                      opClass = C_NOP;
    endcase
  end

  // Immediate forms reuse the register-form ALU codes.
  always_comb begin
    case (opcode)
      5'b01011: aluOp = 5'b00011;
      5'b01100: aluOp = 5'b00101;
      5'b01101: aluOp = 5'b00110;
      default:  aluOp = opcode;
    endcase
  end

  always_comb begin
    case (opClass)
      C_JR:                 lastStep = T3;
      C_UNARY:              lastStep = T4;
      C_ALU, C_IMM, C_LDI:  lastStep = T5;
      C_MULDIV, C_BR:       lastStep = T6;
      C_LD, C_ST:           lastStep = T7;
      default:              lastStep = T3;
    endcase
  end

  // T7 always ends the instruction so a mid-instruction ir change cannot wedge the FSM.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= T0;
    end else begin
      case (state)
        T0:   state <= T1;
        T1:   state <= T2;
        T2: begin
          if (opClass == C_HALT)     state <= HALT;
          else if (opClass == C_NOP) state <= stop ? HALT : T0;
          else                       state <= T3;
        end
        T3, T4, T5, T6, T7: begin
          if (state == lastStep || state == T7) begin
            state <= stop ? HALT : T0;
          end else begin
            case (state)
              T3:      state <= T4;
              T4:      state <= T5;
              T5:      state <= T6;
              default: state <= T7;
            endcase
          end
        end
        HALT:    state <= HALT;
        default: state <= T0;
      endcase
    end
  end

  always_comb begin
    PCout = 1'b0; ZHighout = 1'b0; ZLowout = 1'b0; MDRout = 1'b0;
    Cout = 1'b0; BAout = 1'b0; InPortout = 1'b0;
    PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; ZHIin = 1'b0; ZLOin = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
    operation = '0;
    Run = (state != HALT);
    if (!clr) begin
      case (state)
        T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLOin = 1'b1; end
        T1: begin ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
        T2: begin MDRout = 1'b1; IRin = 1'b1; end
        T3: begin
          case (opClass)
            C_ALU, C_IMM:      begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_UNARY:           begin Grb = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode; end
            C_LD, C_LDI, C_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            C_MULDIV:          begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            C_BR:              begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            C_JR:              begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (opClass)
            C_ALU:             begin Grc = 1'b1; Rout = 1'b1; ZLOin = 1'b1; operation = opcode; end
            C_IMM:             begin Cout = 1'b1; ZLOin = 1'b1; operation = aluOp; end
            C_UNARY:           begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_LD, C_LDI, C_ST: begin Cout = 1'b1; ZLOin = 1'b1; operation = 5'b00011; end
            C_MULDIV: begin
              Grb = 1'b1; Rout = 1'b1; ZHIin = 1'b1; ZLOin = 1'b1; operation = opcode;
            end
            C_BR:              begin PCout = 1'b1; Yin = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          case (opClass)
            C_ALU, C_IMM, C_LDI: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_LD, C_ST:          begin ZLowout = 1'b1; MARin = 1'b1; end
            C_MULDIV:            begin ZLowout = 1'b1; LOin = 1'b1; end
            C_BR:                begin Cout = 1'b1; ZLOin = 1'b1; operation = 5'b00011; end
            default: ;
          endcase
        end
        T6: begin
          case (opClass)
            C_LD:     begin Read = 1'b1; MDRin = 1'b1; end
            C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            C_MULDIV: begin ZHighout = 1'b1; HIin = 1'b1; end
            C_BR:     begin ZLowout = 1'b1; PCin = con_ff; end
            default: ;
          endcase
        end
        T7: begin
          case (opClass)
            C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            C_ST:    Write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: latency/strobe-count table, reference micro-sequence model
// driven by a random opcode stream, and hand sequences for reset, stop, halt and abort.
module tb_control_unit;

  logic clk = 1'b0;
  logic clr, stop, con_ff;
  logic [31:0] ir;
  logic PCout, ZHighout, ZLowout, MDRout, Cout, BAout, InPortout;
  logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin;
  logic Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write, Run;
  logic [4:0] operation;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .ZHighout(ZHighout), .ZLowout(ZLowout), .MDRout(MDRout),
    .Cout(Cout), .BAout(BAout), .InPortout(InPortout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .ZHIin(ZHIin), .ZLOin(ZLOin), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .IncPC(IncPC), .Read(Read), .Write(Write), .operation(operation), .Run(Run)
  );

  localparam logic [24:0] M_WRITE = 25'h1,      M_READ = 25'h2,       M_INCPC = 25'h4;
  localparam logic [24:0] M_ROUT = 25'h8,       M_RIN = 25'h10,       M_GRC = 25'h20;
  localparam logic [24:0] M_GRB = 25'h40,       M_GRA = 25'h80,       M_CONIN = 25'h100;
  localparam logic [24:0] M_ZLOIN = 25'h200,    M_ZHIIN = 25'h400,    M_LOIN = 25'h800;
  localparam logic [24:0] M_HIIN = 25'h1000,    M_YIN = 25'h2000,     M_IRIN = 25'h4000;
  localparam logic [24:0] M_MDRIN = 25'h8000,   M_MARIN = 25'h10000,  M_PCIN = 25'h20000;
  localparam logic [24:0] M_BAOUT = 25'h80000,  M_COUT = 25'h100000,  M_MDROUT = 25'h200000;
  localparam logic [24:0] M_ZLOWOUT = 25'h400000, M_ZHIGHOUT = 25'h800000, M_PCOUT = 25'h1000000;

  logic [24:0] actMask;
  logic [31:0] actual;
  logic [31:0] t0Vec;
  assign actMask = {PCout, ZHighout, ZLowout, MDRout, Cout, BAout, InPortout,
                    PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin,
                    Gra, Grb, Grc, Rin, Rout, IncPC, Read, Write};
  assign actual = {1'b0, actMask, operation, Run};
  assign t0Vec  = {1'b0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, 5'd0, 1'b1};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic checkBus();
    int n;
    n = $countones({PCout, ZHighout, ZLowout, MDRout, Cout, BAout, InPortout, Rout});
    check("bus_one_source", {31'd0, n > 1}, 32'd0);
  endtask

  // Reference model: the register transfers each instruction performs, as a list of steps.
  typedef struct packed { logic [24:0] mask; logic [4:0] op; } step_t;
  step_t expQ[$];
  logic  expHalt;

  function automatic void push(input logic [24:0] m, input logic [4:0] o);
    step_t s;
    s.mask = m;
    s.op   = o;
    expQ.push_back(s);
  endfunction

  function automatic void buildSeq(input logic [4:0] opc, input logic c);
    int code = int'(opc);
    expQ.delete();
    expHalt = (code == 25);
    push(M_PCOUT | M_MARIN | M_INCPC | M_ZLOIN, 5'd0);
    push(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0);
    push(M_MDROUT | M_IRIN, 5'd0);
    if (code >= 3 && code <= 10) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_GRC | M_ROUT | M_ZLOIN, opc);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
    end else if (code >= 11 && code <= 13) begin
      push(M_GRB | M_ROUT | M_YIN, 5'd0);
      push(M_COUT | M_ZLOIN, (code == 11) ? 5'd3 : (code == 12) ? 5'd5 : 5'd6);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
    end else if (code == 16 || code == 17) begin
      push(M_GRB | M_ROUT | M_ZLOIN, opc);
      push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
    end else if (code <= 2) begin
      push(M_GRB | M_BAOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZLOIN, 5'd3);
      if (code == 1) begin
        push(M_ZLOWOUT | M_GRA | M_RIN, 5'd0);
      end else begin
        push(M_ZLOWOUT | M_MARIN, 5'd0);
        if (code == 0) begin
          push(M_READ | M_MDRIN, 5'd0);
          push(M_MDROUT | M_GRA | M_RIN, 5'd0);
        end else begin
          push(M_GRA | M_ROUT | M_MDRIN, 5'd0);
          push(M_WRITE, 5'd0);
        end
      end
    end else if (code == 14 || code == 15) begin
      push(M_GRA | M_ROUT | M_YIN, 5'd0);
      push(M_GRB | M_ROUT | M_ZHIIN | M_ZLOIN, opc);
      push(M_ZLOWOUT | M_LOIN, 5'd0);
      push(M_ZHIGHOUT | M_HIIN, 5'd0);
    end else if (code == 18) begin
      push(M_GRA | M_ROUT | M_CONIN, 5'd0);
      push(M_PCOUT | M_YIN, 5'd0);
      push(M_COUT | M_ZLOIN, 5'd3);
      push(M_ZLOWOUT | (c ? M_PCIN : 25'd0), 5'd0);
    end else if (code == 19) begin
      push(M_GRA | M_ROUT | M_PCIN, 5'd0);
    end
  endfunction

  // All tasks below start and end just after a falling clock edge.
  task automatic runInstr(input logic [4:0] opc, input logic c, input int stopFrom);
    logic toHalt;
    ir = {opc, 27'($urandom)};
    con_ff = c;
    buildSeq(opc, c);
    toHalt = expHalt || (stopFrom >= 0);
    for (int i = 0; i < expQ.size(); i++) begin
      if (i == stopFrom) stop = 1'b1;
      check($sformatf("op%0d_T%0d", opc, i), actual, {1'b0, expQ[i].mask, expQ[i].op, 1'b1});
      checkBus();
      @(negedge clk); #1;
    end
    if (toHalt) check($sformatf("op%0d_halted", opc), actual, 32'd0);
    else        check($sformatf("op%0d_back_T0", opc), actual, t0Vec);
    stop = 1'b0;
  endtask

  task automatic doReset();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
  endtask

  task automatic measure(input logic [4:0] opc, input logic c,
                         output int lat, output int wr, output int rd, output logic halted);
    ir = {opc, 27'($urandom)};
    con_ff = c;
    lat = 0; wr = 0; rd = 0; halted = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (n > 0 && (!Run || (PCout && IncPC))) begin
        halted = !Run;
        break;
      end
      wr += int'(Write);
      rd += int'(Read);
      lat++;
      @(negedge clk); #1;
    end
  endtask

  typedef struct {
    logic [4:0] opc;
    logic       con;
    int         lat;
    int         writes;
    int         reads;
    logic       halts;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int lat, wr, rd;
    logic halted;

    tbl[0]  = '{5'd24, 1'b0, 3, 0, 1, 1'b0};  // nop
    tbl[1]  = '{5'd31, 1'b0, 3, 0, 1, 1'b0};  // undefined
    tbl[2]  = '{5'd20, 1'b1, 3, 0, 1, 1'b0};  // undefined
    tbl[3]  = '{5'd19, 1'b0, 4, 0, 1, 1'b0};  // jr
    tbl[4]  = '{5'd16, 1'b0, 5, 0, 1, 1'b0};  // neg
    tbl[5]  = '{5'd17, 1'b1, 5, 0, 1, 1'b0};  // not
    tbl[6]  = '{5'd3,  1'b0, 6, 0, 1, 1'b0};  // add
    tbl[7]  = '{5'd10, 1'b0, 6, 0, 1, 1'b0};  // rol
    tbl[8]  = '{5'd11, 1'b0, 6, 0, 1, 1'b0};  // addi
    tbl[9]  = '{5'd13, 1'b0, 6, 0, 1, 1'b0};  // ori
    tbl[10] = '{5'd1,  1'b0, 6, 0, 1, 1'b0};  // ldi
    tbl[11] = '{5'd14, 1'b0, 7, 0, 1, 1'b0};  // mul
    tbl[12] = '{5'd15, 1'b0, 7, 0, 1, 1'b0};  // div
    tbl[13] = '{5'd18, 1'b1, 7, 0, 1, 1'b0};  // br taken
    tbl[14] = '{5'd18, 1'b0, 7, 0, 1, 1'b0};  // br not taken
    tbl[15] = '{5'd0,  1'b0, 8, 0, 2, 1'b0};  // ld
    tbl[16] = '{5'd2,  1'b0, 8, 1, 1, 1'b0};  // st
    tbl[17] = '{5'd25, 1'b0, 3, 0, 1, 1'b1};  // halt

    clr = 1'b1; stop = 1'b0; con_ff = 1'b0; ir = '0;

    repeat (3) begin
      @(negedge clk); #1;
      check("reset_quiet", actual, {1'b0, 25'd0, 5'd0, 1'b1});
    end
    clr = 1'b0;
    #1;
    check("reset_release_T0", actual, t0Vec);

    for (int i = 0; i < 18; i++) begin
      measure(tbl[i].opc, tbl[i].con, lat, wr, rd, halted);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_writes", i), 32'(wr), 32'(tbl[i].writes));
      check($sformatf("tbl%0d_reads", i), 32'(rd), 32'(tbl[i].reads));
      check($sformatf("tbl%0d_halt", i), {31'd0, halted}, {31'd0, tbl[i].halts});
      if (halted) doReset();
    end

    // Specific encodings from the test plan.
    runInstr(5'd3, 1'b0, -1);   // 0x19890000 add
    runInstr(5'd2, 1'b0, -1);   // 0x11000000 st
    runInstr(5'd18, 1'b1, -1);  // 0x90000000 br taken
    runInstr(5'd18, 1'b0, -1);  // br not taken
    runInstr(5'd31, 1'b0, -1);  // 0xF8000000 undefined

    // halt opcode, then held with stop wiggling; only clr recovers.
    runInstr(5'd25, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      stop = 1'($urandom);
      check("halt_hold", actual, 32'd0);
      @(negedge clk); #1;
    end
    stop = 1'b0;
    doReset();
    check("halt_clr_T0", actual, t0Vec);

    // stop raised at T4 of add: add completes, then HALT.
    runInstr(5'd3, 1'b0, 4);
    for (int k = 0; k < 3; k++) begin
      check("stop_hold", actual, 32'd0);
      @(negedge clk); #1;
    end
    doReset();
    check("stop_clr_T0", actual, t0Vec);

    // stop together with the halt opcode.
    runInstr(5'd25, 1'b0, 2);
    @(negedge clk); #1;
    check("stop_halt_hold", actual, 32'd0);
    doReset();

    // clr in the middle of st: no Write, restarts at T0.
    ir = {5'd2, 27'd0};
    repeat (6) begin @(negedge clk); #1; end
    check("st_T6_before_abort", actual, {1'b0, M_GRA | M_ROUT | M_MDRIN, 5'd0, 1'b1});
    clr = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("abort_quiet", actual, {1'b0, 25'd0, 5'd0, 1'b1});
      @(negedge clk); #1;
    end
    ir = {5'd24, 27'd0};
    clr = 1'b0;
    #1;
    check("abort_release_T0", actual, t0Vec);
    @(negedge clk); #1;
    check("abort_T1", actual, {1'b0, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1'b1});
    @(negedge clk); #1;
    check("abort_T2", actual, {1'b0, M_MDROUT | M_IRIN, 5'd0, 1'b1});
    @(negedge clk); #1;
    check("abort_back_T0", actual, t0Vec);

    // Random opcode stream against the reference model.
    for (int k = 0; k < 60; k++) begin
      logic [4:0] opc;
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'd25) opc = 5'd24;
      runInstr(opc, 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
